// File: rtl/pixelmem_pkg.sv
// Shared types and default sizes for the pixel memory controller.
package pixelmem_pkg;

    localparam int PIXELMEM_ADDR_W = 9;
    localparam int PIXELMEM_DATA_W = 2;
    localparam int PIXELMEM_DEPTH  = 512;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SETPTR = 2'b01,
        OP_FILL   = 2'b10,
        OP_NOP    = 2'b11
    } host_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/pixelmem_ram.sv
// Simple dual-port pixel RAM: synchronous write, registered read that returns
// zero for addresses beyond DEPTH. Contents are never reset.
module pixelmem_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 2,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_p1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // read stage: same-address write in this cycle is seen one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_p1 <= '0;
        end else if ({1'b0, raddr} < DEPTH_EXT) begin
            rd_data_p1 <= mem[raddr];
        end else begin
            rd_data_p1 <= '0;
        end
    end

    assign rdata = rd_data_p1;

endmodule

// File: rtl/pixelmem_ctrl.sv
// Pixel memory with host write controller (WRITE / SETPTR / FILL commands).
// Optional: PIXELMEM_CLEAR_ON_RESET_EN starts a zero fill when reset releases.
module pixelmem_ctrl
    import pixelmem_pkg::*;
#(
    parameter int ADDR_W = PIXELMEM_ADDR_W,
    parameter int DATA_W = PIXELMEM_DATA_W,
    parameter int DEPTH  = PIXELMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pixelmem_address,
    output logic [DATA_W-1:0] pixelmem_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [1:0]        host_op,
    input  logic [ADDR_W-1:0] host_data,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

`ifdef PIXELMEM_CLEAR_ON_RESET_EN
    localparam state_t RST_STATE = ST_FILL;
    localparam logic   RST_READY = 1'b0;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_READY = 1'b1;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    state_t            state;
    host_op_t          op;
    logic              xfer;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_val;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign op   = host_op_t'(host_op);
    assign xfer = host_valid && host_ready;

    // fill owns the write port; host writes only land while idle
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = host_data[DATA_W-1:0];
        if (state == ST_FILL) begin
            ram_we    = 1'b1;
            ram_waddr = fill_addr;
            ram_wdata = fill_val;
        end else if (xfer && op == OP_WRITE) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RST_STATE;
            host_ready <= RST_READY;
            busy       <= RST_BUSY;
            wr_ptr     <= '0;
            fill_addr  <= '0;
            fill_val   <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        case (op)
                            OP_WRITE: wr_ptr <= wrap_inc(wr_ptr);
                            OP_SETPTR: begin
                                if ({1'b0, host_data} < DEPTH_EXT) begin
                                    wr_ptr <= host_data;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            OP_FILL: begin
                                fill_val   <= host_data[DATA_W-1:0];
                                fill_addr  <= '0;
                                state      <= ST_FILL;
                                host_ready <= 1'b0;
                                busy       <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_FILL: begin
                    if (fill_addr == LAST) begin
                        state      <= ST_IDLE;
                        host_ready <= 1'b1;
                        busy       <= 1'b0;
                        wr_ptr     <= '0;
                        fill_addr  <= '0;
                    end else begin
                        fill_addr <= wrap_inc(fill_addr);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pixelmem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (pixelmem_address),
        .rdata (pixelmem_data)
    );

endmodule

// File: tb/tb_pixelmem_ctrl.sv
// Bench for pixelmem_ctrl: default 512-word build plus a 262-word build for range errors.
module tb_pixelmem_ctrl;
    import pixelmem_pkg::*;

    localparam int DEPTH  = 512;
    localparam int SDEPTH = 262;
`ifdef PIXELMEM_CLEAR_ON_RESET_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic       clk, reset;
    logic [8:0] pixelmem_address, host_data, wr_ptr;
    logic [1:0] pixelmem_data, host_op;
    logic       host_valid, host_ready, busy, err;

    logic [8:0] s_pixelmem_address, s_host_data, s_wr_ptr;
    logic [1:0] s_pixelmem_data, s_host_op;
    logic       s_host_valid, s_host_ready, s_busy, s_err;

    logic [1:0] ref_mem [DEPTH];
    bit         ref_known [DEPTH];
    int         ref_ptr, fill_left;
    bit         ref_err;
    logic [1:0] fill_val, exp_rd;
    bit         exp_known;
    int         vectors, miscompares;

    pixelmem_ctrl dut (
        .clk(clk), .reset(reset), .pixelmem_address(pixelmem_address),
        .pixelmem_data(pixelmem_data), .host_valid(host_valid), .host_ready(host_ready),
        .host_op(host_op), .host_data(host_data), .busy(busy), .wr_ptr(wr_ptr), .err(err)
    );

    pixelmem_ctrl #(.ADDR_W(9), .DATA_W(2), .DEPTH(SDEPTH)) dut_s (
        .clk(clk), .reset(reset), .pixelmem_address(s_pixelmem_address),
        .pixelmem_data(s_pixelmem_data), .host_valid(s_host_valid), .host_ready(s_host_ready),
        .host_op(s_host_op), .host_data(s_host_data), .busy(s_busy), .wr_ptr(s_wr_ptr), .err(s_err)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // One clock of the main DUT: drive inputs, predict the read, advance the model.
    task automatic tick(input logic v, input logic [1:0] op, input logic [8:0] d, input logic [8:0] a);
        int idx;
        host_valid = v; host_op = op; host_data = d; pixelmem_address = a;
        exp_known = ref_known[a];
        exp_rd    = ref_mem[a];
        if (fill_left > 0) begin
            idx = DEPTH - fill_left;
            ref_mem[idx] = fill_val;
            ref_known[idx] = 1'b1;
            fill_left--;
            if (fill_left == 0) ref_ptr = 0;
        end else if (v) begin
            case (op)
                OP_WRITE: begin
                    ref_mem[ref_ptr] = d[1:0];
                    ref_known[ref_ptr] = 1'b1;
                    ref_ptr = (ref_ptr + 1) % DEPTH;
                end
                OP_SETPTR: begin
                    if (int'(d) < DEPTH) ref_ptr = int'(d);
                    else ref_err = 1'b1;
                end
                OP_FILL: begin
                    fill_left = DEPTH;
                    fill_val = d[1:0];
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        fill_left = CLR ? DEPTH : 0;
        fill_val = 2'd0;
        ref_ptr = 0;
        ref_err = 1'b0;
        #10;
        vectors++; if (pixelmem_data !== 2'd0) begin miscompares++; $display("FAIL reset_data got %0d want 0", pixelmem_data); end
        vectors++; if (host_ready !== (fill_left == 0)) begin miscompares++; $display("FAIL reset_ready got %0b want %0b", host_ready, fill_left == 0); end
        vectors++; if (busy !== (fill_left != 0)) begin miscompares++; $display("FAIL reset_busy got %0b want %0b", busy, fill_left != 0); end
        vectors++; if (wr_ptr !== 9'd0) begin miscompares++; $display("FAIL reset_wr_ptr got %0d want 0", wr_ptr); end
        vectors++; if (err !== 1'b0 || s_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b/%0b want 0/0", err, s_err); end
        @(posedge clk);
        @(posedge clk);
        #20 reset = 1'b0;
        #1;
        vectors++; if (host_ready !== (fill_left == 0)) begin miscompares++; $display("FAIL release_ready got %0b want %0b", host_ready, fill_left == 0); end
        for (int i = 0; i < DEPTH + 4 && fill_left > 0; i++) begin
            tick(1'b0, OP_NOP, 9'd0, 9'(i % DEPTH));
            vectors++; if (host_ready !== (fill_left == 0) || busy !== (fill_left != 0)) begin
                miscompares++; $display("FAIL init_fill ready/busy got %0b/%0b at cycle %0d", host_ready, busy, i);
            end
        end
    endtask

    task automatic test_setptr_write();
        tick(1'b1, OP_SETPTR, 9'd5, 9'd0);
        tick(1'b1, OP_WRITE, 9'd1, 9'd0);
        tick(1'b1, OP_WRITE, 9'd2, 9'd0);
        tick(1'b1, OP_WRITE, 9'd3, 9'd0);
        vectors++; if (wr_ptr !== 9'd8) begin miscompares++; $display("FAIL setptr_write wr_ptr got %0d want 8", wr_ptr); end
        tick(1'b0, OP_NOP, 9'd0, 9'd5);
        vectors++; if (pixelmem_data !== 2'd1) begin miscompares++; $display("FAIL read5 got %0d want 1", pixelmem_data); end
        tick(1'b0, OP_NOP, 9'd0, 9'd6);
        vectors++; if (pixelmem_data !== 2'd2) begin miscompares++; $display("FAIL read6 got %0d want 2", pixelmem_data); end
        tick(1'b0, OP_NOP, 9'd0, 9'd7);
        vectors++; if (pixelmem_data !== 2'd3) begin miscompares++; $display("FAIL read7 got %0d want 3", pixelmem_data); end
    endtask

    task automatic test_wrap();
        tick(1'b1, OP_SETPTR, 9'd511, 9'd0);
        tick(1'b1, OP_WRITE, 9'd2, 9'd0);
        tick(1'b1, OP_WRITE, 9'd3, 9'd0);
        tick(1'b0, OP_NOP, 9'd0, 9'd511);
        vectors++; if (wr_ptr !== 9'd1) begin miscompares++; $display("FAIL wrap wr_ptr got %0d want 1", wr_ptr); end
        vectors++; if (pixelmem_data !== 2'd2) begin miscompares++; $display("FAIL wrap read511 got %0d want 2", pixelmem_data); end
        tick(1'b0, OP_NOP, 9'd0, 9'd0);
        vectors++; if (pixelmem_data !== 2'd3) begin miscompares++; $display("FAIL wrap read0 got %0d want 3", pixelmem_data); end
    endtask

    task automatic test_same_cycle();
        tick(1'b1, OP_SETPTR, 9'd10, 9'd10);
        tick(1'b1, OP_WRITE, 9'd1, 9'd10);
        tick(1'b1, OP_SETPTR, 9'd10, 9'd10);
        tick(1'b1, OP_WRITE, 9'd2, 9'd10);
        vectors++; if (pixelmem_data !== 2'd1) begin miscompares++; $display("FAIL same_cycle old got %0d want 1", pixelmem_data); end
        tick(1'b0, OP_NOP, 9'd0, 9'd10);
        vectors++; if (pixelmem_data !== 2'd2) begin miscompares++; $display("FAIL same_cycle new got %0d want 2", pixelmem_data); end
    endtask

    task automatic test_fill();
        int low;
        tick(1'b1, OP_FILL, 9'd3, 9'd0);
        low = 0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fill_start busy got %0b want 1", busy); end
        for (int i = 0; i < DEPTH + 4 && host_ready !== 1'b1; i++) begin
            low++;
            tick(1'b1, OP_WRITE, 9'd1, 9'($urandom_range(0, DEPTH - 1)));
            if (exp_known) begin
                vectors++; if (pixelmem_data !== exp_rd) begin miscompares++; $display("FAIL fill_read got %0d want %0d", pixelmem_data, exp_rd); end
            end
            vectors++; if (busy !== (fill_left != 0)) begin miscompares++; $display("FAIL fill_busy got %0b want %0b", busy, fill_left != 0); end
        end
        vectors++; if (low !== DEPTH) begin miscompares++; $display("FAIL fill_duration got %0d want %0d", low, DEPTH); end
        vectors++; if (wr_ptr !== 9'd0) begin miscompares++; $display("FAIL fill_wr_ptr got %0d want 0", wr_ptr); end
        tick(1'b1, OP_WRITE, 9'd1, 9'd0);
        vectors++; if (wr_ptr !== 9'd1) begin miscompares++; $display("FAIL held_write wr_ptr got %0d want 1", wr_ptr); end
        for (int a = 0; a < DEPTH; a++) begin
            tick(1'b0, OP_NOP, 9'd0, 9'(a));
            vectors++; if (pixelmem_data !== exp_rd) begin miscompares++; $display("FAIL fill_sweep addr %0d got %0d want %0d", a, pixelmem_data, exp_rd); end
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 2));
            if (op == OP_FILL) op = OP_NOP;
            tick(1'($urandom_range(0, 1)), op, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
            if (exp_known) begin
                vectors++; if (pixelmem_data !== exp_rd) begin miscompares++; $display("FAIL rand_read got %0d want %0d", pixelmem_data, exp_rd); end
            end
            vectors++; if (wr_ptr !== 9'(ref_ptr) || err !== ref_err || host_ready !== 1'b1) begin
                miscompares++; $display("FAIL rand_state ptr/err/rdy got %0d/%0b/%0b want %0d/%0b/1", wr_ptr, err, host_ready, ref_ptr, ref_err);
            end
        end
        host_valid = 1'b0;
    endtask

    task automatic test_small_err();
        s_host_valid = 1'b1; s_host_op = OP_SETPTR; s_host_data = 9'd300;
        @(posedge clk); #1;
        vectors++; if (s_wr_ptr !== 9'd0 || s_err !== 1'b1) begin miscompares++; $display("FAIL small_setptr300 ptr/err got %0d/%0b want 0/1", s_wr_ptr, s_err); end
        s_host_data = 9'd261;
        @(posedge clk); #1;
        vectors++; if (s_wr_ptr !== 9'd261 || s_err !== 1'b1) begin miscompares++; $display("FAIL small_setptr261 ptr/err got %0d/%0b want 261/1", s_wr_ptr, s_err); end
        s_host_op = OP_WRITE; s_host_data = 9'd1;
        @(posedge clk); #1;
        vectors++; if (s_wr_ptr !== 9'd0) begin miscompares++; $display("FAIL small_wrap ptr got %0d want 0", s_wr_ptr); end
        s_host_data = 9'd2;
        @(posedge clk); #1;
        s_host_op = OP_SETPTR; s_host_data = 9'd262;
        @(posedge clk); #1;
        vectors++; if (s_wr_ptr !== 9'd1 || s_err !== 1'b1) begin miscompares++; $display("FAIL small_setptr262 ptr/err got %0d/%0b want 1/1", s_wr_ptr, s_err); end
        s_host_valid = 1'b0;
        s_pixelmem_address = 9'd300;
        @(posedge clk); #1;
        vectors++; if (s_pixelmem_data !== 2'd0) begin miscompares++; $display("FAIL small_read300 got %0d want 0", s_pixelmem_data); end
        s_pixelmem_address = 9'd261;
        @(posedge clk); #1;
        vectors++; if (s_pixelmem_data !== 2'd1) begin miscompares++; $display("FAIL small_read261 got %0d want 1", s_pixelmem_data); end
        s_pixelmem_address = 9'd0;
        @(posedge clk); #1;
        vectors++; if (s_pixelmem_data !== 2'd2) begin miscompares++; $display("FAIL small_read0 got %0d want 2", s_pixelmem_data); end
    endtask

    task automatic test_reset_mid_fill();
        tick(1'b1, OP_FILL, 9'd2, 9'd0);
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, OP_NOP, 9'd0, 9'($urandom_range(0, DEPTH - 1)));
        end
        #20 reset = 1'b1;
        #1;
        ref_ptr = 0;
        ref_err = 1'b0;
        fill_left = CLR ? DEPTH : 0;
        fill_val = 2'd0;
        vectors++; if (pixelmem_data !== 2'd0 || wr_ptr !== 9'd0 || err !== 1'b0 || s_err !== 1'b0) begin
            miscompares++; $display("FAIL midfill_reset data/ptr/err/s_err got %0d/%0d/%0b/%0b want 0/0/0/0", pixelmem_data, wr_ptr, err, s_err);
        end
        vectors++; if (host_ready !== (fill_left == 0) || busy !== (fill_left != 0)) begin
            miscompares++; $display("FAIL midfill_reset ready/busy got %0b/%0b", host_ready, busy);
        end
        @(posedge clk);
        #20 reset = 1'b0;
        #1;
        vectors++; if (host_ready !== (fill_left == 0)) begin miscompares++; $display("FAIL midfill_release ready got %0b want %0b", host_ready, fill_left == 0); end
        for (int i = 0; i < DEPTH + 4 && fill_left > 0; i++) begin
            tick(1'b0, OP_NOP, 9'd0, 9'd0);
            vectors++; if (busy !== (fill_left != 0)) begin miscompares++; $display("FAIL clear_fill busy got %0b at %0d", busy, i); end
        end
        for (int a = 0; a < DEPTH; a++) begin
            tick(1'b0, OP_NOP, 9'd0, 9'(a));
            vectors++; if (pixelmem_data !== exp_rd) begin miscompares++; $display("FAIL post_reset_sweep addr %0d got %0d want %0d", a, pixelmem_data, exp_rd); end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        host_valid = 1'b0; host_op = OP_NOP; host_data = '0; pixelmem_address = '0;
        s_host_valid = 1'b0; s_host_op = OP_NOP; s_host_data = '0; s_pixelmem_address = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 2'd0;
            ref_known[i] = CLR;
        end
        test_reset();
        test_setptr_write();
        test_wrap();
        test_same_cycle();
        test_fill();
        test_random();
        test_small_err();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
